// File: rtl/aha_sram_banked.sv
// Banked single-port SRAM with per-byte write enables, a registered bank-steered
// read path, and an optional post-reset zero-clear sequencer.
module aha_sram_banked #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 12,
  parameter int NUM_BANKS = 2,
  parameter int INIT_EN   = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CEn,
  input  logic [DATA_W/8-1:0]   WEn,
  input  logic [ADDR_W-1:0]     A,
  input  logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     Q,
  output logic                  INIT_BUSY
);

  localparam int NB   = DATA_W / 8;
  localparam int BSW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RW   = (NUM_BANKS > 1) ? ADDR_W - BSW : ADDR_W;
  localparam int BDEP = (2 ** ADDR_W) / NUM_BANKS;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            r_state;
  logic [RW-1:0]     r_cnt;
  logic              r_busy;
  logic [BSW-1:0]    r_bidx;

  logic              w_acc;
  logic              w_rd;
  logic              w_wr;
  logic [BSW-1:0]    w_bank;
  logic [RW-1:0]     w_row;
  logic [DATA_W-1:0] w_rd_bank [NUM_BANKS];

  // Clear sequencer: one row per cycle across all banks, BDEP cycles total.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= (INIT_EN != 0) ? ST_CLEAR : ST_READY;
      r_cnt   <= '0;
      r_busy  <= (INIT_EN != 0);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: ;
        default: r_state <= ST_READY;
      endcase
    end
  end

  assign INIT_BUSY = r_busy;
  assign w_acc     = ~CEn & ~r_busy;
  assign w_rd      = w_acc & (&WEn);
  assign w_wr      = w_acc & ~(&WEn);
  assign w_row     = A[RW-1:0];

  generate
    if (NUM_BANKS > 1) begin : g_bsel
      assign w_bank = A[ADDR_W-1 -: BSW];
    end else begin : g_nobsel
      assign w_bank = '0;
    end
  endgenerate

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     r_bidx <= '0;
    else if (w_rd) r_bidx <= w_bank;
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [DATA_W-1:0] r_mem [BDEP];
      logic [DATA_W-1:0] r_rd;
      logic              w_ce;

      assign w_ce = w_acc && (w_bank == BSW'(b));

      always_ff @(posedge CLK) begin
        if (r_state == ST_CLEAR) begin
          r_mem[r_cnt] <= '0;
        end else if (w_ce && w_wr) begin
          for (int unsigned i = 0; i < NB; i++) begin
            if (!WEn[i]) r_mem[w_row][8*i +: 8] <= D[8*i +: 8];
          end
        end
      end

      // Per-bank read register holds its last read, so Q holds across idle/write cycles.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)               r_rd <= '0;
        else if (w_ce && w_rd)   r_rd <= r_mem[w_row];
      end

      assign w_rd_bank[b] = r_rd;
    end
  endgenerate

  assign Q = w_rd_bank[r_bidx];

endmodule

// File: tb/tb_aha_sram_banked.sv
// Directed, table-driven bench for aha_sram_banked: default 2-bank/clear config
// plus a 4-bank instance with the clear sequencer disabled.
module tb_aha_sram_banked;

  logic        clk = 1'b0;
  logic        rst, cen;
  logic [7:0]  wen;
  logic [11:0] a;
  logic [63:0] d, q;
  logic        busy;

  logic        rst4, cen4;
  logic [7:0]  wen4;
  logic [11:0] a4;
  logic [63:0] d4, q4;
  logic        busy4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aha_sram_banked #(.DATA_W(64), .ADDR_W(12), .NUM_BANKS(2), .INIT_EN(1)) u_dut (
    .CLK(clk), .RESET(rst), .CEn(cen), .WEn(wen), .A(a), .D(d),
    .Q(q), .INIT_BUSY(busy)
  );

  aha_sram_banked #(.DATA_W(64), .ADDR_W(12), .NUM_BANKS(4), .INIT_EN(0)) u_dut4 (
    .CLK(clk), .RESET(rst4), .CEn(cen4), .WEn(wen4), .A(a4), .D(d4),
    .Q(q4), .INIT_BUSY(busy4)
  );

  typedef struct {
    logic        cen;
    logic [7:0]  wen;
    logic [11:0] a;
    logic [63:0] d;
    logic [63:0] q;
  } vec_t;

  vec_t        vt [12];
  logic [63:0] pat [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts sampled cycles with INIT_BUSY high, starting at the current negedge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;

    vt[0]  = '{1'b0, 8'h00, 12'h005, 64'h1122334455667788, 64'h0};
    vt[1]  = '{1'b0, 8'hFF, 12'h005, 64'h0,                64'h1122334455667788};
    vt[2]  = '{1'b0, 8'hF0, 12'h005, 64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788};
    vt[3]  = '{1'b0, 8'hFF, 12'h005, 64'h0,                64'h11223344FFFFFFFF};
    vt[4]  = '{1'b0, 8'h00, 12'h010, 64'hAAAAAAAAAAAAAAAA, 64'h11223344FFFFFFFF};
    vt[5]  = '{1'b0, 8'h00, 12'h810, 64'h5555555555555555, 64'h11223344FFFFFFFF};
    vt[6]  = '{1'b0, 8'hFF, 12'h010, 64'h0,                64'hAAAAAAAAAAAAAAAA};
    vt[7]  = '{1'b0, 8'hFF, 12'h810, 64'h0,                64'h5555555555555555};
    vt[8]  = '{1'b0, 8'hFF, 12'h010, 64'h0,                64'hAAAAAAAAAAAAAAAA};
    vt[9]  = '{1'b1, 8'hFF, 12'h810, 64'h0,                64'hAAAAAAAAAAAAAAAA};
    vt[10] = '{1'b1, 8'h00, 12'h810, 64'hDEADBEEFDEADBEEF, 64'hAAAAAAAAAAAAAAAA};
    vt[11] = '{1'b0, 8'hFF, 12'h810, 64'h0,                64'h5555555555555555};

    pat[0] = 64'hAAAAAAAAAAAAAAAA;
    pat[1] = 64'h5555555555555555;
    pat[2] = 64'h0123456789ABCDEF;
    pat[3] = 64'hFEDCBA9876543210;

    rst = 1'b1; cen = 1'b1; wen = '1; a = '0; d = '0;
    rst4 = 1'b1; cen4 = 1'b1; wen4 = '1; a4 = '0; d4 = '0;
    repeat (2) @(negedge clk);
    chk("reset_q", q, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h1);
    chk("reset_q4", q4, 64'h0);
    chk("reset_busy4", {63'h0, busy4}, 64'h0);

    rst = 1'b0; rst4 = 1'b0;
    count_busy(n);
    chk("clear_cycles", 64'(n), 64'd2048);
    chk("busy_done", {63'h0, busy}, 64'h0);
    chk("busy4_after_reset", {63'h0, busy4}, 64'h0);

    for (int i = 0; i < 20; i++) begin
      cen = 1'b0; wen = '1; a = 12'($urandom_range(0, 4095));
      @(negedge clk);
      chk($sformatf("cleared_rd_%03h", a), q, 64'h0);
    end

    for (int i = 0; i < 12; i++) begin
      cen = vt[i].cen; wen = vt[i].wen; a = vt[i].a; d = vt[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d", i), q, vt[i].q);
    end

    // Writes attempted during INIT_BUSY, with a reset pulse at clear row 1000.
    cen = 1'b0; wen = 8'h00; a = 12'h020; d = 64'h0BADF00D0BADF00D;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_q", q, 64'h0);
    rst = 1'b0;
    repeat (1000) @(negedge clk);
    chk("busy_at_row1000", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    wen = '1;
    chk("restart_clear_cycles", 64'(n), 64'd2048);
    a = 12'h020; @(negedge clk); chk("busy_write_ignored", q, 64'h0);
    a = 12'h005; @(negedge clk); chk("recleared_005", q, 64'h0);
    a = 12'h810; @(negedge clk); chk("recleared_810", q, 64'h0);
    cen = 1'b1;

    for (int b = 0; b < 4; b++) begin
      cen4 = 1'b0; wen4 = 8'h00; a4 = {2'(b), 10'h010}; d4 = pat[b];
      @(negedge clk);
    end
    chk("b4_write_holds_q", q4, 64'h0);
    for (int k = 0; k < 5; k++) begin
      cen4 = 1'b0; wen4 = '1; a4 = {2'(k % 4), 10'h010};
      @(negedge clk);
      chk($sformatf("b4_read%0d", k), q4, pat[k % 4]);
    end
    cen4 = 1'b1; a4 = 12'hC10;
    repeat (2) @(negedge clk);
    chk("b4_idle_hold", q4, pat[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
